// File: rtl/hazard_ctrl.sv
// hazard_ctrl: D-stage stall and forwarding-select generation for the
// five-stage MIPS core. Tracks destination/Tnew of instructions in E, M, W.
// Optional stall-cycle counter: define HAZARD_PERF_EN to build it.
module hazard_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  d_rs,
   input  logic [4:0]  d_rt,
   input  logic [4:0]  d_a3,
   input  logic        d_calc_r,
   input  logic        d_calc_i,
   input  logic        d_load,
   input  logic        d_store,
   input  logic        d_branch,
   input  logic        d_jal,
   input  logic        d_jr,
   output logic        stall,
   output logic [1:0]  fwd_d_rs,
   output logic [1:0]  fwd_d_rt,
   output logic [1:0]  fwd_e_rs,
   output logic [1:0]  fwd_e_rt,
   output logic        fwd_m_rt,
   output logic [31:0] stall_cnt
);

   typedef struct packed {
      logic [4:0] a3;
      logic [1:0] tnew;
      logic [4:0] rs;
      logic [4:0] rt;
   } rec_t;

   // E keeps the full record; M and W only keep the fields anything reads
   // afterwards (M.rs and all of W except a3 have no consumer).
   rec_t       e_q, e_d;
   logic [4:0] m_a3_q, m_a3_d, m_rt_q, m_rt_d, w_a3_q, w_a3_d;
   logic [1:0] m_tnew_q, m_tnew_d;

   logic       writes, use_rs, use_rt, hz_rs, hz_rt;
   logic [1:0] tnew_d, tuse_rs, tuse_rt;

   function automatic logic [1:0] dec_sat(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

   // D-stage select: nearest ready producer wins; W is always ready
   function automatic logic [1:0] sel_d(input logic [4:0] r,
                                        input logic [4:0] ea3, input logic [1:0] et,
                                        input logic [4:0] ma3, input logic [1:0] mt,
                                        input logic [4:0] wa3);
      if (r == 5'd0)                    return 2'b00;
      if (ea3 == r && et == 2'd0)       return 2'b01;
      if (ma3 == r && mt == 2'd0)       return 2'b10;
      if (wa3 == r)                     return 2'b11;
      return 2'b00;
   endfunction

   // E-stage select: M when its result is ready, else W
   function automatic logic [1:0] sel_e(input logic [4:0] r,
                                        input logic [4:0] ma3, input logic [1:0] mt,
                                        input logic [4:0] wa3);
      if (r == 5'd0)                    return 2'b00;
      if (ma3 == r && mt == 2'd0)       return 2'b01;
      if (wa3 == r)                     return 2'b10;
      return 2'b00;
   endfunction

   // decode what the D instruction produces (Tnew) and when it needs operands (Tuse)
   always_comb begin
      writes  = d_calc_r | d_calc_i | d_load | d_jal;
      tnew_d  = 2'd0;
      if (d_calc_r | d_calc_i) tnew_d = 2'd1;
      if (d_load)              tnew_d = 2'd2;
      use_rs  = d_branch | d_jr | d_calc_r | d_calc_i | d_load | d_store;
      tuse_rs = (d_branch | d_jr) ? 2'd0 : 2'd1;
      use_rt  = d_branch | d_calc_r | d_store;
      tuse_rt = d_branch ? 2'd0 : (d_store ? 2'd2 : 2'd1);
   end

   // stall when a used source is produced later than it is needed
   always_comb begin
      hz_rs = use_rs && (d_rs != 5'd0) &&
              ((e_q.a3 == d_rs && e_q.tnew > tuse_rs) ||
               (m_a3_q == d_rs && m_tnew_q > tuse_rs));
      hz_rt = use_rt && (d_rt != 5'd0) &&
              ((e_q.a3 == d_rt && e_q.tnew > tuse_rt) ||
               (m_a3_q == d_rt && m_tnew_q > tuse_rt));
      stall = hz_rs | hz_rt;
   end

   // forwarding-mux selects for D compare, ALU operands and DM write data
   always_comb begin
      fwd_d_rs = sel_d(d_rs, e_q.a3, e_q.tnew, m_a3_q, m_tnew_q, w_a3_q);
      fwd_d_rt = sel_d(d_rt, e_q.a3, e_q.tnew, m_a3_q, m_tnew_q, w_a3_q);
      fwd_e_rs = sel_e(e_q.rs, m_a3_q, m_tnew_q, w_a3_q);
      fwd_e_rt = sel_e(e_q.rt, m_a3_q, m_tnew_q, w_a3_q);
      fwd_m_rt = (m_rt_q != 5'd0) && (w_a3_q == m_rt_q);
   end

   // next records: bubble into E on stall, M/W always advance with Tnew aging
   always_comb begin
      e_d = '0;
      if (!stall) begin
         e_d.a3   = writes ? d_a3 : 5'd0;
         e_d.tnew = tnew_d;
         e_d.rs   = d_rs;
         e_d.rt   = d_rt;
      end
      m_a3_d   = e_q.a3;
      m_tnew_d = dec_sat(e_q.tnew);
      m_rt_d   = e_q.rt;
      w_a3_d   = m_a3_q;
   end

   // shadow record registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q      <= '0;
         m_a3_q   <= 5'd0;
         m_tnew_q <= 2'd0;
         m_rt_q   <= 5'd0;
         w_a3_q   <= 5'd0;
      end else begin
         e_q      <= e_d;
         m_a3_q   <= m_a3_d;
         m_tnew_q <= m_tnew_d;
         m_rt_q   <= m_rt_d;
         w_a3_q   <= w_a3_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // saturating count of stalled cycles
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   // stall counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) stall_cnt_q <= 32'd0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 32'h0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core, the consumer of the per-instruction class flags produced by the D-stage decoder. It keeps its own E/M/W shadow records of each in-flight instruction's destination register and remaining cycles-to-result (Tnew). From these it issues the D-stage stall and every forwarding-mux select. It sits beside the D/E, E/M and M/W pipeline registers and drives their enables and the forwarding muxes.

## Interface
- No parameters.
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- d_rs, d_rt  in  5 each  source register fields of the D-stage instruction
- d_a3  in  5  resolved destination register of the D-stage instruction (rd/rt/31)
- d_calc_r, d_calc_i, d_load, d_store, d_branch, d_jal, d_jr  in  1 each  one-hot class flags of the D-stage instruction (all 0 = nop/j)
- stall  out  1  freeze PC and F/D; bubble into D/E
- fwd_d_rs, fwd_d_rt  out  2 each  D-stage compare operands: 00 RF, 01 from E, 10 from M, 11 from W
- fwd_e_rs, fwd_e_rt  out  2 each  ALU operands: 00 pipeline, 01 from M, 10 from W
- fwd_m_rt  out  1  DM write data: 0 pipeline, 1 from W
- stall_cnt  out  32  stall-cycle counter (see Configuration)

## Operation
- Record = {a3[4:0], tnew[1:0], rs[4:0], rt[4:0]}; three records: E, M, W.
- D-stage producer info:
  - writes = calc_r|calc_i|load|jal; a3_d = writes ? d_a3 : 0.
  - tnew_d: calc_r/calc_i 1, load 2, jal 0.
- Tuse:
  - rs: branch/jr 0; calc_r/calc_i/load/store 1; otherwise unused.
  - rt: branch 0; calc_r 1; store 2; otherwise unused.
- stall = rs hazard OR rt hazard.
  - For a used operand r != 0: (E.a3==r && E.tnew>Tuse) || (M.a3==r && M.tnew>Tuse).
- D forwarding, nearest stage first, register != 0 only:
  - E match with E.tnew==0 → 01.
  - else M match with M.tnew==0 → 10.
  - else W match → 11.
  - else 00.
- E forwarding on E.rs/E.rt:
  - M match with M.tnew==0 → 01.
  - else W match → 10.
  - else 00.
- fwd_m_rt = (M.rt!=0 && W.a3==M.rt).
- Register 0 never matches and never stalls.

## Timing
- Outputs are combinational from the current records and the D inputs. There is no added latency.
- Record update on each rising clk edge:
  - E ← stall ? zero record (bubble) : {a3_d, tnew_d, d_rs, d_rt}.
  - M ← E with tnew decremented, saturating at 0.
  - W ← M with tnew decremented, saturating at 0.
- Stall does not hold M/W; they keep advancing.
- Reset, including mid-operation, asynchronously clears all records to 0 and stall_cnt to 0. As a result, stall and every fwd_* output are 0 during and immediately after reset.
- Simultaneous matches in several stages: the nearest stage wins.
- stall_cnt increments on each rising edge with stall=1 and saturates at 32'hFFFF_FFFF. A stall cycle still counts in the same cycle that reset deasserts.

## Configuration
- HAZARD_PERF_EN:
  - When defined, the stall_cnt counter is built as specified above.
  - When undefined, stall_cnt is tied to 32'h0 and no counter flops exist. All other behaviour is identical.

## Test plan
- Reset asserted while a load hazard is pending → records clear; stall=0, all fwd_*=0, stall_cnt=0 immediately.
- lw $1 then addu $2,$1,$3 → stall=1 for exactly 1 cycle, then addu in E with fwd_e_rs=10 (from W); stall_cnt=1 (with HAZARD_PERF_EN).
- lw $1 then beq $1,$0 → stall=1 for 2 cycles, then fwd_d_rs=11 (from W); stall_cnt=2 with HAZARD_PERF_EN, 0 without.
- addu $4,$5,$6 then sw $4,0($0) → no stall; when sw is in E, fwd_e_rt=01; one cycle later fwd_m_rt=1.
- jal then jr $31 → no stall, fwd_d_rs=01 (from E).
- ori $0,$1,5 then addu $2,$0,$0 → stall=0, all fwd_*=00.
